fifo_sync_ctrl: RTL and testbench
=================================

Name: fifo_sync_ctrl

Overview:
- Single-clock FIFO that succeeds the basic sync FIFO in the shared logic library.
- Generalised in depth and width, with selectable read mode: first-word-fall-through (show-ahead) or registered read with a valid strobe.
- Adds runtime almost-full/almost-empty thresholds, flush, sticky overflow/underflow error flags, and exact occupancy under simultaneous read and write.
- Used as the standard buffer in peripheral TX/RX paths and AHB-side bridges.

Parameters:
ADDR_WIDTH, 4, log2 of depth; depth DEPTH = 2**ADDR_WIDTH entries (exactly DEPTH storage words)
DATA_WIDTH, 8, data word width in bits
FWFT, 1, 1 = show-ahead read (q valid while !rd_empty); 0 = registered read (q valid 1 cycle after accepted rd_req)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous clear of pointers/count/q-valid; storage contents untouched
wr_req  input  1  write request
data  input  DATA_WIDTH  write data
wr_full  output  1  fifo_num == DEPTH
wr_almost_full  output  1  fifo_num >= af_thresh
rd_req  input  1  read request
q  output  DATA_WIDTH  read data
rd_valid  output  1  q holds valid data (see Behaviour)
rd_empty  output  1  fifo_num == 0
rd_almost_empty  output  1  fifo_num <= ae_thresh
fifo_num  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
af_thresh  input  ADDR_WIDTH+1  almost-full threshold, static or quasi-static
ae_thresh  input  ADDR_WIDTH+1  almost-empty threshold
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty
err_clr  input  1  clears overflow/underflow

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at clk edge):
  - wr_addr=rd_addr=0, fifo_num=0, q=0 (FWFT=0), rd_valid=0, overflow=0, underflow=0.
  - Hence rd_empty=1, wr_full=0.
  - Storage array is not reset.
  - rst has priority over flush, err_clr and requests; reset mid-transfer discards all contents.
- Accept rules, evaluated on registered state at the edge:
  - wr_acc = wr_req & !wr_full.
  - rd_acc = rd_req & !rd_empty.
  - A write while full is dropped; pointers and storage are unchanged, overflow <= 1.
  - A read while empty is dropped; underflow <= 1.
- Count update:
  - fifo_num += wr_acc - rd_acc, so both accepted leaves it unchanged.
  - Full + both requests: read accepted, write rejected, overflow set; fifo_num goes to DEPTH-1.
  - Empty + both requests: write accepted, read rejected, underflow set; fifo_num goes to 1.
- Pointers: ADDR_WIDTH bits, +1 per accept, natural wrap from DEPTH-1 to 0. fifo_num disambiguates full from empty.
- Flags:
  - rd_empty, wr_full, wr_almost_full and rd_almost_empty are combinational from registered fifo_num, so they change in the cycle after the causing edge.
  - af_thresh=0 makes wr_almost_full permanently 1.
  - ae_thresh >= DEPTH makes rd_almost_empty permanently 1.
- Read mode FWFT=1:
  - q = mem[rd_addr] combinationally; rd_valid = !rd_empty.
  - A word written into an empty FIFO appears on q the cycle after the write edge.
  - rd_req acts as "pop current word".
- Read mode FWFT=0:
  - On rd_acc, q <= mem[rd_addr] and rd_valid <= 1; otherwise rd_valid <= 0 and q holds its last value.
  - Latency is 1 cycle from the accepted rd_req edge to data.
- Read-during-write same address: occurs only when the FIFO is empty, and the read is then rejected, so no bypass path is required.
- flush=1 (no rst):
  - Pointers and fifo_num go to 0; rd_valid goes to 0.
  - Requests in the same cycle are ignored and set no error flags.
  - overflow/underflow are held.
- Error flags:
  - err_clr=1 clears both flags.
  - A new error event in the same cycle wins (flag set).

Test Plan:
- ADDR_WIDTH=3, FWFT=1, reset, then write 0x01..0x08 on consecutive cycles -> fifo_num steps 1..8; wr_full=1 after 8th edge; q=0x01, rd_valid=1 from cycle after first write.
- Full, then wr_req+rd_req together with data=0xAA -> 0x01 popped, 0xAA dropped, fifo_num=7, overflow=1; err_clr -> overflow=0.
- Empty, then wr_req(0x55)+rd_req together -> fifo_num=1, underflow=1, q=0x55; next cycle rd_req -> rd_empty=1.
- FWFT=0: write 0x10,0x20 then read twice back-to-back -> rd_valid high on the two cycles after each accepted read, q=0x10 then 0x20; rd_valid=0 afterwards, q holds 0x20.
- af_thresh=6, ae_thresh=2: fill to 6 -> wr_almost_full rises after 6th write; drain to 2 -> rd_almost_empty rises; simultaneous rd/wr at 5 -> flags stable.
- Streaming 20 words with random wr_req/rd_req and flush at word 11 -> fifo_num=0 next cycle, error flags unchanged, subsequent data order intact across pointer wrap; rst asserted mid-stream -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_sync_ctrl
// Single-clock FIFO with exact occupancy, runtime almost-full/almost-empty
// thresholds, flush, sticky overflow/underflow flags and a choice of read mode.
//
// Parameters
//   ADDR_WIDTH : log2 of depth (DEPTH = 2**ADDR_WIDTH storage words)
//   DATA_WIDTH : data word width
//   FWFT       : 1 = show-ahead (q valid while !rd_empty)
//                0 = registered read (q/rd_valid one cycle after accepted rd_req)
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   flush             : clears pointers, count and read-valid; storage untouched
//   wr_req, data      : write request and write data
//   wr_full           : fifo_num == DEPTH
//   wr_almost_full    : fifo_num >= af_thresh
//   rd_req, q         : read request (pop) and read data
//   rd_valid          : q holds valid data
//   rd_empty          : fifo_num == 0
//   rd_almost_empty   : fifo_num <= ae_thresh
//   fifo_num          : occupancy 0..DEPTH
//   af_thresh/ae_thresh : runtime thresholds
//   overflow/underflow  : sticky error flags, cleared by err_clr
// -----------------------------------------------------------------------------
module fifo_sync_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   fifo_num,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam int                CW        = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     DEPTH_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CW-1:0]         num_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_evt;
  logic                  unf_evt;

  // Status flags decode the registered count only, so they move one cycle
  // after the edge that changed the occupancy.
  assign wr_full         = (fifo_num == DEPTH_CNT);
  assign rd_empty        = (fifo_num == '0);
  assign wr_almost_full  = (fifo_num >= af_thresh);
  assign rd_almost_empty = (fifo_num <= ae_thresh);

  // Reset and flush both override requests; a flushed request is not an error.
  assign wr_acc  = wr_req & ~wr_full  & ~flush & ~rst;
  assign rd_acc  = rd_req & ~rd_empty & ~flush & ~rst;
  assign ovf_evt = wr_req &  wr_full  & ~flush & ~rst;
  assign unf_evt = rd_req &  rd_empty & ~flush & ~rst;

  // NOTE: the storage array is deliberately left out of reset; fifo_num and the
  // pointers define which words are meaningful, and a resettable array would
  // stop the memory from mapping onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= data;
  end

  always_comb begin
    // NOTE: default first so every path assigns num_next and no latch is inferred.
    num_next = fifo_num;
    unique case ({wr_acc, rd_acc})
      2'b10:   num_next = fifo_num + CW'(1);
      2'b01:   num_next = fifo_num - CW'(1);
      default: num_next = fifo_num;  // idle, or read+write leaves count unchanged
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      fifo_num <= '0;
    end else begin
      if (wr_acc) wr_addr <= wr_addr + 1'b1;  // natural wrap at DEPTH-1
      if (rd_acc) rd_addr <= rd_addr + 1'b1;
      fifo_num <= num_next;
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow  & ~err_clr);
      underflow <= unf_evt | (underflow & ~err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; a read is a pop of the visible word.
      // Same-address read/write only happens when empty, where the read is
      // rejected, so no write-to-read bypass is needed.
      assign q        = mem[rd_addr];
      assign rd_valid = ~rd_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] q_r;
      logic                  valid_r;

      // q keeps its last value when no read is accepted; only the strobe drops.
      always_ff @(posedge clk) begin
        if (rst) begin
          q_r     <= '0;
          valid_r <= 1'b0;
        end else if (flush) begin
          valid_r <= 1'b0;
        end else if (rd_acc) begin
          q_r     <= mem[rd_addr];
          valid_r <= 1'b1;
        end else begin
          valid_r <= 1'b0;
        end
      end

      assign q        = q_r;
      assign rd_valid = valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_ctrl
// Drives a show-ahead and a registered-read instance (ADDR_WIDTH=3) with the
// same stimulus and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fifo_sync_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst, flush, wr_req, rd_req, err_clr;
  logic [DW-1:0] data;
  logic [AW:0]   af_thresh, ae_thresh;

  // show-ahead instance outputs
  logic          f1_full, f1_afull, f1_valid, f1_empty, f1_aempty, f1_ovf, f1_unf;
  logic [DW-1:0] f1_q;
  logic [AW:0]   f1_num;
  // registered-read instance outputs
  logic          f0_full, f0_afull, f0_valid, f0_empty, f0_aempty, f0_ovf, f0_unf;
  logic [DW-1:0] f0_q;
  logic [AW:0]   f0_num;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic          m_ovf, m_unf, m_v0;
  logic [DW-1:0] m_q0;

  always #5 clk = ~clk;

  fifo_sync_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wr_req(wr_req), .data(data),
    .wr_full(f1_full), .wr_almost_full(f1_afull), .rd_req(rd_req), .q(f1_q),
    .rd_valid(f1_valid), .rd_empty(f1_empty), .rd_almost_empty(f1_aempty),
    .fifo_num(f1_num), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(f1_ovf), .underflow(f1_unf), .err_clr(err_clr)
  );

  fifo_sync_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .wr_req(wr_req), .data(data),
    .wr_full(f0_full), .wr_almost_full(f0_afull), .rd_req(rd_req), .q(f0_q),
    .rd_valid(f0_valid), .rd_empty(f0_empty), .rd_almost_empty(f0_aempty),
    .fifo_num(f0_num), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .overflow(f0_ovf), .underflow(f0_unf), .err_clr(err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic r, input logic f, input logic w, input logic rd,
                      input logic [DW-1:0] d, input logic ec);
    int  n;
    bit  full, empty;
    rst = r; flush = f; wr_req = w; rd_req = rd; data = d; err_clr = ec;
    @(posedge clk);
    n     = mq.size();
    full  = (n == DEPTH);
    empty = (n == 0);
    if (r) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_q0 = '0; m_v0 = 1'b0;
    end else if (f) begin
      mq.delete();
      m_v0 = 1'b0;
      if (ec) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      m_v0 = 1'b0;
      if (rd && !empty) begin
        m_q0 = mq.pop_front();
        m_v0 = 1'b1;
      end
      if (w && !full) mq.push_back(d);
      m_ovf = (w && full)   || (m_ovf && !ec);
      m_unf = (rd && empty) || (m_unf && !ec);
    end
    #1;
    n = mq.size();
    check("fwft.fifo_num",   32'(f1_num),    32'(n));
    check("fwft.rd_empty",   32'(f1_empty),  32'(n == 0));
    check("fwft.wr_full",    32'(f1_full),   32'(n == DEPTH));
    check("fwft.almost_full",  32'(f1_afull),  32'(n >= int'(af_thresh)));
    check("fwft.almost_empty", 32'(f1_aempty), 32'(n <= int'(ae_thresh)));
    check("fwft.overflow",   32'(f1_ovf),    32'(m_ovf));
    check("fwft.underflow",  32'(f1_unf),    32'(m_unf));
    check("fwft.rd_valid",   32'(f1_valid),  32'(n != 0));
    if (n != 0) check("fwft.q", 32'(f1_q), 32'(mq[0]));
    check("reg.fifo_num",    32'(f0_num),    32'(n));
    check("reg.wr_full",     32'(f0_full),   32'(n == DEPTH));
    check("reg.rd_empty",    32'(f0_empty),  32'(n == 0));
    check("reg.overflow",    32'(f0_ovf),    32'(m_ovf));
    check("reg.underflow",   32'(f0_unf),    32'(m_unf));
    check("reg.rd_valid",    32'(f0_valid),  32'(m_v0));
    check("reg.q",           32'(f0_q),      32'(m_q0));
  endtask

  initial begin
    logic [DW-1:0] wd;
    m_ovf = 1'b0; m_unf = 1'b0; m_v0 = 1'b0; m_q0 = '0;
    af_thresh = 4'd6; ae_thresh = 4'd2;

    // reset
    step(1, 0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 0, 8'h00, 0);

    // fill with 0x01..0x08: count steps up, full after the 8th edge
    for (int i = 1; i <= DEPTH; i++) step(0, 0, 1, 0, DW'(i), 0);

    // full with both requests: head popped, 0xAA dropped, overflow set
    step(0, 0, 1, 1, 8'hAA, 0);
    step(0, 0, 0, 0, 8'h00, 1);  // err_clr

    // drain the remaining seven words
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 1, 8'h00, 0);

    // empty with both requests: write taken, read rejected, underflow set
    step(0, 0, 1, 1, 8'h55, 0);
    step(0, 0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 1);
    // err_clr coincident with a new underflow: flag stays set
    step(0, 0, 0, 1, 8'h00, 1);
    step(0, 0, 0, 0, 8'h00, 1);

    // registered-read latency: two writes, two back-to-back reads, idle
    step(0, 0, 1, 0, 8'h10, 0);
    step(0, 0, 1, 0, 8'h20, 0);
    step(0, 0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 8'h00, 0);

    // thresholds: fill to 6, drain to 2, refill to 5, simultaneous rd/wr
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, DW'(8'h30 + i), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h00, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, DW'(8'h40 + i), 0);
    step(0, 0, 1, 1, 8'h4F, 0);
    step(0, 0, 1, 1, 8'h50, 0);

    // degenerate thresholds: af=0 always asserted, ae>=DEPTH always asserted
    af_thresh = 4'd0; ae_thresh = 4'd8;
    step(0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 1, 0, 8'h51, 0);
    af_thresh = 4'd6; ae_thresh = 4'd2;

    // push to full and beyond so overflow is set entering the stream
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, DW'(8'h60 + i), 0);

    // random stream: flush mid-run (flags held), pointer wrap, reset late
    wd = 8'h80;
    for (int i = 0; i < 90; i++) begin
      logic w, rd;
      w  = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      if (i == 30) step(0, 1, w, rd, wd, 0);
      else if (i == 40) step(0, 0, 0, 1, wd, 0);
      else if (i == 70) step(1, 0, w, rd, wd, 0);
      else step(0, 0, w, rd, wd, 0);
      wd = wd + 8'd1;
    end

    // flush while error flags are set: flags held, requests ignored
    step(0, 0, 0, 1, 8'h00, 0);
    while (mq.size() != 0) step(0, 0, 0, 1, 8'h00, 0);
    step(0, 0, 0, 1, 8'h00, 0);
    step(0, 0, 1, 0, 8'hC1, 0);
    step(0, 1, 1, 1, 8'hC2, 0);
    step(0, 0, 0, 0, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
